// File: rtl/morra_match_driver.sv
// morra_match_driver: drives LFSR-generated matches into the MorraCinese core and checks each result against a reference model.
// Define MORRA_DRV_INJECT_EN to force PRIMO to NO_MOVE on every 4th issued manche.
module morra_match_driver #(
    parameter int MAX_ISSUED = 63
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] cfg_len,
    input  logic [7:0] seed1,
    input  logic [7:0] seed2,
    input  logic [1:0] MANCHE,
    input  logic [1:0] PARTITA,
    output logic [1:0] PRIMO,
    output logic [1:0] SECONDO,
    output logic       INIZIA,
    output logic       busy,
    output logic       done,
    output logic       mismatch,
    output logic       timeout,
    output logic [7:0] err_count,
    output logic [4:0] score1,
    output logic [4:0] score2,
    output logic [4:0] played,
    output logic [1:0] result
);
    typedef enum logic [2:0] {IDLE, CFG, CFGCHK, ISSUE, CHECK, DONE} state_t;
    localparam logic [7:0] MAX_I = 8'(MAX_ISSUED);
    state_t state, state_n;
    logic [7:0] lfsr1, lfsr2, lfsr1_n, lfsr2_n, issued;
    logic [4:0] max_pl, s1_n, s2_n, pl_n;
    logic [1:0] mv1, mv2, mv1_n, mv2_n, lw_who, lw_mv, exp_m, exp_mm, exp_p, win_p;
    logic       accept, inval, cmp, err, at_max;

    function automatic logic [7:0] step(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    function automatic logic [1:0] to_move(input logic [1:0] b);
        return b == 2'b00 ? 2'b01 : b;
    endfunction

    function automatic logic beats(input logic [1:0] a, input logic [1:0] b);
        return (a == 2'b01 && b == 2'b11) || (a == 2'b11 && b == 2'b10) || (a == 2'b10 && b == 2'b01);
    endfunction

    always_comb begin
        accept  = state == IDLE && start;
        lfsr1_n = step(lfsr1);
        lfsr2_n = step(lfsr2);
`ifdef MORRA_DRV_INJECT_EN
        mv1_n   = issued[1:0] == 2'b11 ? 2'b00 : to_move(lfsr1_n[1:0]);
`else
        mv1_n   = to_move(lfsr1_n[1:0]);
`endif
        mv2_n   = to_move(lfsr2_n[1:0]);
        // the last decisive winner may not repeat the move that won it
        inval   = mv1 == 2'b00 || mv2 == 2'b00 || (lw_who == 2'b01 && mv1 == lw_mv) || (lw_who == 2'b10 && mv2 == lw_mv);
        exp_m   = inval ? 2'b00 : mv1 == mv2 ? 2'b11 : beats(mv1, mv2) ? 2'b01 : 2'b10;
        s1_n    = score1 + 5'(exp_m == 2'b01);
        s2_n    = score2 + 5'(exp_m == 2'b10);
        pl_n    = played + 5'(exp_m != 2'b00);
        win_p   = (pl_n >= 5'd4 && s1_n >= s2_n + 5'd2) ? 2'b01 :
                  (pl_n >= 5'd4 && s2_n >= s1_n + 5'd2) ? 2'b10 :
                  pl_n == max_pl ? (s1_n > s2_n ? 2'b01 : s2_n > s1_n ? 2'b10 : 2'b11) : 2'b00;
        exp_mm  = state == CHECK ? exp_m : 2'b00;
        exp_p   = state == CHECK ? win_p : 2'b00;
        cmp     = state == CHECK || state == CFGCHK;
        err     = cmp && (MANCHE != exp_mm || PARTITA != exp_p);
        at_max  = issued >= MAX_I;
        state_n = state;
        case (state)
            IDLE:    state_n = accept ? CFG : IDLE;
            CFG:     state_n = CFGCHK;
            CFGCHK:  state_n = ISSUE;
            ISSUE:   state_n = CHECK;
            CHECK:   state_n = (win_p != 2'b00 || PARTITA != 2'b00 || at_max) ? DONE : ISSUE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            PRIMO     <= 2'b00;
            SECONDO   <= 2'b00;
            INIZIA    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mismatch  <= 1'b0;
            timeout   <= 1'b0;
            err_count <= 8'd0;
            score1    <= 5'd0;
            score2    <= 5'd0;
            played    <= 5'd0;
            result    <= 2'b00;
            lfsr1     <= 8'h01;
            lfsr2     <= 8'h01;
            issued    <= 8'd0;
            max_pl    <= 5'd4;
            mv1       <= 2'b00;
            mv2       <= 2'b00;
            lw_who    <= 2'b00;
            lw_mv     <= 2'b00;
        end else begin
            state   <= state_n;
            PRIMO   <= state_n == CFG ? cfg_len[3:2] : state_n == ISSUE ? mv1_n : 2'b00;
            SECONDO <= state_n == CFG ? cfg_len[1:0] : state_n == ISSUE ? mv2_n : 2'b00;
            INIZIA  <= state_n == CFG;
            busy    <= state_n inside {CFG, CFGCHK, ISSUE, CHECK};
            done    <= state_n == DONE;
            if (accept) begin
                lfsr1     <= seed1 == 8'd0 ? 8'h01 : seed1;
                lfsr2     <= seed2 == 8'd0 ? 8'h01 : seed2;
                issued    <= 8'd0;
                max_pl    <= 5'(cfg_len) + 5'd4;
                score1    <= 5'd0;
                score2    <= 5'd0;
                played    <= 5'd0;
                result    <= 2'b00;
                lw_who    <= 2'b00;
                mismatch  <= 1'b0;
                timeout   <= 1'b0;
                err_count <= 8'd0;
            end
            if (state_n == ISSUE) begin
                lfsr1  <= lfsr1_n;
                lfsr2  <= lfsr2_n;
                mv1    <= mv1_n;
                mv2    <= mv2_n;
                issued <= issued + 8'd1;
            end
            if (err) begin
                mismatch  <= 1'b1;
                err_count <= err_count + 8'(err_count != 8'hFF);
            end
            if (state == CHECK) begin
                score1 <= s1_n;
                score2 <= s2_n;
                played <= pl_n;
                result <= win_p;
                if (exp_m == 2'b01 || exp_m == 2'b10) begin
                    lw_who <= exp_m;
                    lw_mv  <= exp_m == 2'b01 ? mv1 : mv2;
                end else if (exp_m == 2'b11) begin
                    lw_who <= 2'b00;
                end
                if (at_max && win_p == 2'b00 && PARTITA == 2'b00) timeout <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_morra_match_driver.sv
// tb_morra_match_driver: directed checks of morra_match_driver against a scripted core stub.
module tb_morra_match_driver;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] cfg_len = 4'd0;
    logic [7:0] seed1 = 8'd0, seed2 = 8'd0;
    logic [1:0] MANCHE = 2'b00, PARTITA = 2'b00;
    logic [1:0] PRIMO, SECONDO, result;
    logic       INIZIA, busy, done, mismatch, timeout;
    logic [7:0] err_count;
    logic [4:0] score1, score2, played;
    int errors = 0, checks = 0;
    int mode = 0, idx = 0;
    logic clr = 1'b0;
    logic [1:0] tab_m [4];
    logic [1:0] tab_p [4];

    morra_match_driver #(.MAX_ISSUED(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len), .seed1(seed1), .seed2(seed2),
        .MANCHE(MANCHE), .PARTITA(PARTITA), .PRIMO(PRIMO), .SECONDO(SECONDO), .INIZIA(INIZIA),
        .busy(busy), .done(done), .mismatch(mismatch), .timeout(timeout), .err_count(err_count),
        .score1(score1), .score2(score2), .played(played), .result(result)
    );

    always #5 clk = ~clk;

    // core stub: mode 0 replays a table per move, 1 always claims a P1 win, 2 answers NONE forever
    always @(posedge clk) begin
        if (clr) idx <= 0;
        if (!INIZIA && (PRIMO != 2'b00 || SECONDO != 2'b00)) begin
            if (mode == 0) begin
                MANCHE  <= idx < 4 ? tab_m[idx] : 2'b00;
                PARTITA <= idx < 4 ? tab_p[idx] : 2'b00;
                if (!clr) idx <= idx + 1;
            end else begin
                MANCHE  <= mode == 1 ? 2'b01 : 2'b11;
                PARTITA <= 2'b00;
            end
        end else begin
            MANCHE  <= mode == 1 ? 2'b01 : 2'b00;
            PARTITA <= 2'b00;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic begin_match(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        cfg_len = c;
        seed1 = a;
        seed2 = b;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    initial begin
        tick(2);
        chk("rst_primo", PRIMO, 0);
        chk("rst_inizia", INIZIA, 0);
        chk("rst_busy", busy, 0);
        chk("rst_result", result, 0);
        rst_n = 1'b1;
        tick(1);
        // P1 ROCK,PAPER,ROCK,SCISSORS vs P2 SCISSORS,SCISSORS,PAPER,ROCK
        mode = 0;
        tab_m = '{2'b01, 2'b10, 2'b10, 2'b10};
        tab_p = '{2'b00, 2'b00, 2'b00, 2'b10};
        begin_match(4'b0001, 8'hF0, 8'h11);
        chk("cfg_inizia", INIZIA, 1);
        chk("cfg_primo", PRIMO, 2'b00);
        chk("cfg_secondo", SECONDO, 2'b01);
        chk("cfg_busy", busy, 1);
        tick(1);
        chk("cfgchk_inizia", INIZIA, 0);
        tick(1);
        chk("m1_primo", PRIMO, 2'b01);
        chk("m1_secondo", SECONDO, 2'b11);
        tick(2);
        chk("m2_primo", PRIMO, 2'b10);
        chk("m1_score1", score1, 1);
        start = 1'b1;
        cfg_len = 4'b1111;
        tick(1);
        start = 1'b0;
        tick(1);
        chk("m3_primo", PRIMO, 2'b01);
        chk("m3_secondo", SECONDO, 2'b10);
        chk("m2_score2", score2, 1);
        tick(2);
        chk("m4_primo", PRIMO, 2'b11);
        chk("m4_secondo", SECONDO, 2'b01);
        tick(2);
        chk("a_done", done, 1);
        chk("a_busy", busy, 0);
        chk("a_score1", score1, 1);
        chk("a_score2", score2, 3);
        chk("a_played", played, 4);
        chk("a_result", result, 2'b10);
        chk("a_mismatch", mismatch, 0);
        chk("a_errcnt", err_count, 0);
        tick(1);
        chk("a_done_pulse", done, 0);
        chk("a_result_hold", result, 2'b10);
        // P1 wins with ROCK, then repeats ROCK against SCISSORS
        tab_m = '{2'b01, 2'b00, 2'b00, 2'b00};
        tab_p = '{2'b00, 2'b00, 2'b00, 2'b00};
        begin_match(4'b0000, 8'h02, 8'h11);
        tick(2);
        chk("b_m1_primo", PRIMO, 2'b01);
        chk("b_m1_secondo", SECONDO, 2'b11);
        tick(2);
        chk("b_played1", played, 1);
        tick(2);
        chk("b_played_inval", played, 1);
        chk("b_score1", score1, 1);
        chk("b_mismatch", mismatch, 0);
        chk("b_issue", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("b_rst_primo", PRIMO, 0);
        chk("b_rst_busy", busy, 0);
        chk("b_rst_played", played, 0);
        chk("b_rst_score1", score1, 0);
        tick(1);
        rst_n = 1'b1;
        // identical seeds give draw-only play; stub falsely reports P1 wins
        mode = 1;
        begin_match(4'b0000, 8'hF0, 8'hF0);
        chk("c_busy_after_rst", busy, 1);
        tick(2);
        chk("c_mismatch_early", mismatch, 1);
        chk("c_errcnt_early", err_count, 1);
        tick(8);
        chk("c_done", done, 1);
        chk("c_errcnt", err_count, 5);
        chk("c_result", result, 2'b11);
        chk("c_played", played, 4);
        chk("c_score1", score1, 0);
        // core never ends; abort on issued limit
        mode = 2;
        tick(1);
        begin_match(4'b1111, 8'hF0, 8'hF0);
        chk("d_cfg_primo", PRIMO, 2'b11);
        chk("d_mismatch_clr", mismatch, 0);
        tick(12);
        chk("d_not_done", done, 0);
        chk("d_not_timeout", timeout, 0);
        tick(2);
        chk("d_done", done, 1);
        chk("d_timeout", timeout, 1);
        chk("d_played", played, 6);
        chk("d_result", result, 2'b00);
        chk("d_mismatch", mismatch, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
